// File: rtl/wireframe_edge_raster.sv
// wireframe_edge_raster: draws a triangle's three edges into the wireframe SRAM, walks the covered
// rows for colour-fill, then erases the same edges.
//   clk, n_rst (async, active-low)
//   start, v0_x..v2_y   : accept a triangle while idle (signed screen coordinates)
//   fill_ready          : colour-fill finished the current row
//   wf_we/wf_addr/wf_data : one wireframe pixel write per cycle (data 1 draw, 0 erase)
//   fill_en/fill_row    : row hand-off to colour-fill
//   busy, done          : status
module wireframe_edge_raster #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int ADDR_W = 19
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic signed [15:0]  v0_x,
  input  logic signed [15:0]  v0_y,
  input  logic signed [15:0]  v1_x,
  input  logic signed [15:0]  v1_y,
  input  logic signed [15:0]  v2_x,
  input  logic signed [15:0]  v2_y,
  input  logic                fill_ready,
  output logic                wf_we,
  output logic [ADDR_W-1:0]   wf_addr,
  output logic                wf_data,
  output logic                fill_en,
  output logic [15:0]         fill_row,
  output logic                busy,
  output logic                done
);
  typedef enum logic [2:0] {IDLE, EDGE_INIT, EDGE_STEP, ROW_ISSUE, ROW_WAIT, DONE} state_t;
  state_t state, state_n;
  logic signed [15:0] vx [3];
  logic signed [15:0] vy [3];
  logic [1:0] e, en;
  logic erase, sxn, syn, skip, at_end, step_x, step_y, on;
  logic signed [15:0] x, y, xe, ye, row, lo01, hi01, ymin_r, ymax_r, ymin, ymax;
  logic signed [16:0] ddx, ddy, adx, ady;
  logic signed [17:0] dx, dy, err, err_n;
  logic signed [18:0] e2, dx19, dy19;
  logic [ADDR_W-1:0] addr;
  assign en = e == 2'd2 ? 2'd0 : e + 2'd1;
  always_comb begin
    ddx = {vx[en][15], vx[en]} - {vx[e][15], vx[e]};
    ddy = {vy[en][15], vy[en]} - {vy[e][15], vy[e]};
    adx = ddx[16] ? -ddx : ddx;
    ady = ddy[16] ? -ddy : ddy;
    e2 = {err, 1'b0};
    dx19 = {dx[17], dx};
    dy19 = {dy[17], dy};
    step_x = e2 >= dy19;
    step_y = e2 <= dx19;
    err_n = err + (step_x ? dy : 18'sd0) + (step_y ? dx : 18'sd0);
    at_end = x == xe && y == ye;
    on = x >= 16'sd0 && x < 16'(WIDTH) && y >= 16'sd0 && y < 16'(HEIGHT);
    addr = ADDR_W'(y) * ADDR_W'(WIDTH) + ADDR_W'(x);
    lo01 = vy[0] < vy[1] ? vy[0] : vy[1];
    hi01 = vy[0] > vy[1] ? vy[0] : vy[1];
    ymin_r = lo01 < vy[2] ? lo01 : vy[2];
    ymax_r = hi01 > vy[2] ? hi01 : vy[2];
    skip = ymax_r < 16'sd0 || ymin_r >= 16'(HEIGHT);
    ymin = ymin_r < 16'sd0 ? 16'sd0 : ymin_r;
    ymax = ymax_r > 16'(HEIGHT - 1) ? 16'(HEIGHT - 1) : ymax_r;
  end
  // After the third edge: erase pass ends the triangle, draw pass goes to rows
  // unless no row is on screen, in which case the erase pass starts at once.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = start ? EDGE_INIT : IDLE;
      EDGE_INIT: state_n = EDGE_STEP;
      EDGE_STEP: if (at_end) state_n = e != 2'd2 ? EDGE_INIT : erase ? DONE : skip ? EDGE_INIT : ROW_ISSUE;
      ROW_ISSUE: state_n = ROW_WAIT;
      ROW_WAIT:  if (fill_ready) state_n = row == ymax ? EDGE_INIT : ROW_ISSUE;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      vx[0] <= '0;
      vx[1] <= '0;
      vx[2] <= '0;
      vy[0] <= '0;
      vy[1] <= '0;
      vy[2] <= '0;
      e <= '0;
      erase <= 1'b0;
      x <= '0;
      y <= '0;
      xe <= '0;
      ye <= '0;
      dx <= '0;
      dy <= '0;
      err <= '0;
      sxn <= 1'b0;
      syn <= 1'b0;
      row <= '0;
      wf_we <= 1'b0;
      wf_addr <= '0;
      wf_data <= 1'b0;
      fill_en <= 1'b0;
      fill_row <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        vx[0] <= v0_x;
        vx[1] <= v1_x;
        vx[2] <= v2_x;
        vy[0] <= v0_y;
        vy[1] <= v1_y;
        vy[2] <= v2_y;
      end
      e <= state == IDLE ? 2'd0 : state == EDGE_STEP && at_end ? en : e;
      // Any return to EDGE_INIT from the row phase or after the third drawn edge begins erasing.
      erase <= state == IDLE ? 1'b0
             : erase | (state_n == EDGE_INIT && (state == ROW_WAIT || (state == EDGE_STEP && e == 2'd2)));
      if (state == EDGE_INIT) begin
        x <= vx[e];
        y <= vy[e];
        xe <= vx[en];
        ye <= vy[en];
        dx <= {1'b0, adx};
        dy <= -{1'b0, ady};
        err <= {1'b0, adx} - {1'b0, ady};
        sxn <= ddx[16];
        syn <= ddy[16];
      end else if (state == EDGE_STEP && !at_end) begin
        err <= err_n;
        if (step_x) x <= sxn ? x - 16'sd1 : x + 16'sd1;
        if (step_y) y <= syn ? y - 16'sd1 : y + 16'sd1;
      end
      row <= state == EDGE_STEP ? ymin : state == ROW_WAIT && fill_ready ? row + 16'sd1 : row;
      wf_we <= state == EDGE_STEP && on;
      if (state == EDGE_STEP && on) wf_addr <= addr;
      wf_data <= state == EDGE_STEP && !erase;
      fill_en <= state == ROW_ISSUE;
      if (state == ROW_ISSUE) fill_row <= row;
      busy <= state_n != IDLE && state_n != DONE;
      done <= state_n == DONE;
    end
  end
endmodule

// File: tb/tb_wireframe_edge_raster.sv
// tb_wireframe_edge_raster: randomized and directed checks against a Bresenham event model
module tb_wireframe_edge_raster;
  localparam int W = 640, H = 480;
  logic clk = 1'b0, n_rst = 1'b0, start = 1'b0, fill_ready = 1'b0;
  logic signed [15:0] v0_x = '0, v0_y = '0, v1_x = '0, v1_y = '0, v2_x = '0, v2_y = '0;
  logic wf_we, wf_data, fill_en, busy, done;
  logic [18:0] wf_addr;
  logic [15:0] fill_row;
  int vectors = 0, miss = 0;
  int log_q[$];
  int exp_q[$];
  bit mem [int];
  int n_draw, n_erase, n_fill, done_cnt, proto, busy_bad, dly, cnt;
  bit pending;
  logic [15:0] last_row;

  always #5 clk = ~clk;

  wireframe_edge_raster dut (
    .clk(clk), .n_rst(n_rst), .start(start),
    .v0_x(v0_x), .v0_y(v0_y), .v1_x(v1_x), .v1_y(v1_y), .v2_x(v2_x), .v2_y(v2_y),
    .fill_ready(fill_ready), .wf_we(wf_we), .wf_addr(wf_addr), .wf_data(wf_data),
    .fill_en(fill_en), .fill_row(fill_row), .busy(busy), .done(done)
  );

  // Event log codes: 1<<20|addr draw write, 2<<20|addr erase write, 3<<20|row fill issue.
  always @(negedge clk) begin
    fill_ready = 1'b0;
    if (!n_rst) pending = 1'b0;
    else begin
      if (pending) begin
        if (cnt == 0) begin
          fill_ready = 1'b1;
          pending = 1'b0;
          if (fill_row !== last_row) proto++;
        end else cnt--;
      end
      if (wf_we) begin
        mem[int'(wf_addr)] = wf_data;
        log_q.push_back((wf_data ? 1 : 2) * 2**20 + int'(wf_addr));
        if (wf_data) n_draw++; else n_erase++;
      end
      if (fill_en) begin
        if (pending) proto++;
        pending = 1'b1;
        cnt = dly;
        last_row = fill_row;
        n_fill++;
        log_q.push_back(3 * 2**20 + int'(fill_row));
      end
      if (done) begin
        done_cnt++;
        if (busy) busy_bad++;
      end
    end
  end

  task automatic add_edge(input int x0, input int y0, input int x1, input int y1, input int d);
    int x = x0, y = y0, e2;
    int ddx = x1 > x0 ? x1 - x0 : x0 - x1;
    int ddy = y1 > y0 ? y0 - y1 : y1 - y0;
    int err = ddx + ddy;
    for (int k = 0; k < 200000; k++) begin
      if (x >= 0 && x < W && y >= 0 && y < H) exp_q.push_back(d * 2**20 + y * W + x);
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= ddy) begin err += ddy; x += (x1 > x0) ? 1 : -1; end
      if (e2 <= ddx) begin err += ddx; y += (y1 > y0) ? 1 : -1; end
    end
  endtask

  task automatic build_exp(input int ax, input int ay, input int bx, input int by, input int cx, input int cy);
    int lo, hi;
    exp_q.delete();
    add_edge(ax, ay, bx, by, 1);
    add_edge(bx, by, cx, cy, 1);
    add_edge(cx, cy, ax, ay, 1);
    lo = ay < by ? ay : by;
    lo = lo < cy ? lo : cy;
    hi = ay > by ? ay : by;
    hi = hi > cy ? hi : cy;
    if (!(hi < 0 || lo >= H)) begin
      if (lo < 0) lo = 0;
      if (hi > H - 1) hi = H - 1;
      for (int r = lo; r <= hi; r++) exp_q.push_back(3 * 2**20 + r);
    end
    add_edge(ax, ay, bx, by, 2);
    add_edge(bx, by, cx, cy, 2);
    add_edge(cx, cy, ax, ay, 2);
  endtask

  task automatic run_tri(input int ax, input int ay, input int bx, input int by, input int cx, input int cy,
                         input int d, input bit poke, input string nm);
    int cyc = 0, nz = 0;
    bit poked = 1'b0;
    build_exp(ax, ay, bx, by, cx, cy);
    log_q.delete();
    dly = d; n_fill = 0; n_draw = 0; n_erase = 0; proto = 0; done_cnt = 0; busy_bad = 0;
    @(posedge clk); #1;
    v0_x = 16'(ax); v0_y = 16'(ay); v1_x = 16'(bx); v1_y = 16'(by); v2_x = 16'(cx); v2_y = 16'(cy);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin miss++; $display("FAIL %s busy_after_start got %b expected 1", nm, busy); end
    v0_x = 16'($urandom); v0_y = 16'($urandom); v1_x = 16'($urandom);
    v1_y = 16'($urandom); v2_x = 16'($urandom); v2_y = 16'($urandom);
    while (done_cnt == 0 && cyc < 20000) begin
      if (poke && !poked && n_fill > 0) begin start = 1'b1; poked = 1'b1; end
      else start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (log_q.size() != exp_q.size()) begin
      miss++;
      $display("FAIL %s event_count got %0d expected %0d", nm, log_q.size(), exp_q.size());
    end
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (log_q[i] !== exp_q[i]) begin
        miss++;
        $display("FAIL %s event[%0d] got %h expected %h", nm, i, log_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (done_cnt !== 1) begin miss++; $display("FAIL %s done_pulses got %0d expected 1", nm, done_cnt); end
    vectors++;
    if (busy_bad !== 0) begin miss++; $display("FAIL %s busy_with_done got %0d expected 0", nm, busy_bad); end
    vectors++;
    if (proto !== 0) begin miss++; $display("FAIL %s fill_handshake_errors got %0d expected 0", nm, proto); end
    vectors++;
    if (n_draw !== n_erase) begin miss++; $display("FAIL %s draw_vs_erase got %0d expected %0d", nm, n_erase, n_draw); end
    foreach (mem[a]) if (mem[a]) nz++;
    vectors++;
    if (nz !== 0) begin miss++; $display("FAIL %s buffer_dirty got %0d expected 0", nm, nz); end
  endtask

  task automatic check_zero_outputs(input string nm);
    vectors++;
    if ({wf_we, wf_addr, wf_data, fill_en, fill_row, busy, done} !== '0) begin
      miss++;
      $display("FAIL %s outputs got we=%b addr=%0d data=%b fen=%b row=%0d busy=%b done=%b expected all 0",
               nm, wf_we, wf_addr, wf_data, fill_en, fill_row, busy, done);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    n_rst = 1'b1;
    @(posedge clk); #1;
    check_zero_outputs("idle_after_reset");
  endtask

  task automatic test_horizontal();
    run_tri(10, 5, 14, 5, 12, 5, 2, 1'b0, "horizontal");
    vectors++;
    if (log_q[0] !== 2**20 + 3210) begin miss++; $display("FAIL horizontal first_write got %h expected %h", log_q[0], 2**20 + 3210); end
    vectors++;
    if (n_fill !== 1 || last_row !== 16'd5) begin miss++; $display("FAIL horizontal rows got n=%0d last=%0d expected n=1 last=5", n_fill, last_row); end
  endtask

  task automatic test_diag_rows();
    run_tri(0, 0, 3, 3, 0, 3, 20, 1'b0, "diag");
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (log_q[i] !== 2**20 + i * 641) begin miss++; $display("FAIL diag write[%0d] got %h expected %h", i, log_q[i], 2**20 + i * 641); end
    end
    vectors++;
    if (n_fill !== 4) begin miss++; $display("FAIL diag rows got %0d expected 4", n_fill); end
  endtask

  task automatic test_degenerate();
    run_tri(7, 7, 7, 7, 7, 7, 0, 1'b0, "degenerate");
    vectors++;
    if (n_draw !== 3 || log_q[0] !== 2**20 + 4487) begin
      miss++; $display("FAIL degenerate draws got n=%0d first=%h expected n=3 first=%h", n_draw, log_q[0], 2**20 + 4487);
    end
    vectors++;
    if (n_fill !== 1 || last_row !== 16'd7) begin miss++; $display("FAIL degenerate rows got n=%0d last=%0d expected n=1 last=7", n_fill, last_row); end
  endtask

  task automatic test_clip();
    run_tri(-5, -5, 2, -5, 2, 2, 1, 1'b0, "clip");
    vectors++;
    if (n_fill !== 3 || last_row !== 16'd2) begin miss++; $display("FAIL clip rows got n=%0d last=%0d expected n=3 last=2", n_fill, last_row); end
    run_tri(0, -10, 20, -3, 5, -8, 0, 1'b0, "offscreen");
    vectors++;
    if (n_fill !== 0 || n_draw !== 0) begin miss++; $display("FAIL offscreen got fills=%0d draws=%0d expected 0 0", n_fill, n_draw); end
    run_tri(630, 470, 650, 475, 635, 490, 1, 1'b0, "clip_far");
  endtask

  task automatic test_start_during_row();
    run_tri(0, 0, 3, 3, 0, 3, 20, 1'b1, "start_in_row_wait");
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    v0_x = 16'sd0; v0_y = 16'sd0; v1_x = 16'sd300; v1_y = 16'sd200; v2_x = 16'sd5; v2_y = 16'sd100;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    n_rst = 1'b0;
    #1;
    check_zero_outputs("reset_mid_edge");
    @(posedge clk); #1;
    check_zero_outputs("reset_mid_held");
    n_rst = 1'b1;
    mem.delete();
    run_tri(4, 9, 1, 2, 8, 3, 1, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int t = 0; t < 10; t++) begin
      int cx = int'($urandom_range(0, 700)) - 30;
      int cy = int'($urandom_range(0, 540)) - 30;
      run_tri(cx + int'($urandom_range(0, 80)) - 40, cy + int'($urandom_range(0, 80)) - 40,
              cx + int'($urandom_range(0, 80)) - 40, cy + int'($urandom_range(0, 80)) - 40,
              cx + int'($urandom_range(0, 80)) - 40, cy + int'($urandom_range(0, 80)) - 40,
              int'($urandom_range(0, 3)), 1'b0, $sformatf("random%0d", t));
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_diag_rows();
    test_degenerate();
    test_clip();
    test_start_during_row();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
